fecha_bcd_editor: RTL and testbench

//  Calendar date register: 2-digit BCD day/month/year (years 2000-2099), user-editable via up/down buttons.

---
 rtl/fecha_bcd_editor_pkg.sv | 42 ++++
 rtl/fecha_bcd_editor_if.sv | 27 ++
 rtl/fecha_bcd_editor_bcd_step.sv | 33 +++
 rtl/fecha_bcd_editor.sv | 160 ++++++++++++++++
 tb/tb_fecha_bcd_editor.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fecha_bcd_editor_pkg.sv
// Shared types, BCD constants and calendar helpers for the BCD date editor.
// Optional macro DATE_LEAP_EN: February gets 29 days in years divisible by 4.
package fecha_pkg;

  typedef enum logic [1:0] {
    FIELD_DAY   = 2'd0,
    FIELD_MONTH = 2'd1,
    FIELD_YEAR  = 2'd2,
    FIELD_NONE  = 2'd3
  } field_e;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_28 = 8'h28;
  localparam logic [7:0] BCD_29 = 8'h29;
  localparam logic [7:0] BCD_30 = 8'h30;
  localparam logic [7:0] BCD_31 = 8'h31;
  localparam logic [7:0] BCD_99 = 8'h99;

`ifdef DATE_LEAP_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif

  function automatic logic bcd_valid(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // (10*t + u) mod 4 == (2*t[0] + u) mod 4, so only the low bits matter.
  function automatic logic [7:0] bcd_max_day(input logic [7:0] month, input logic [7:0] year);
    logic [1:0] m4;
    m4 = year[1:0] + {year[4], 1'b0};
    case (month)
      8'h02:                      return (LEAP_EN && (m4 == 2'b00)) ? BCD_29 : BCD_28;
      8'h04, 8'h06, 8'h09, 8'h11: return BCD_30;
      default:                    return BCD_31;
    endcase
  endfunction

endpackage

// File: rtl/fecha_bcd_editor_if.sv
// Control/data bundle between the button/RTC front-end and the BCD date editor.
interface fecha_bcd_editor_if;
  logic       edit_en;
  logic       btn_up;
  logic       btn_dn;
  logic [1:0] field_sel;
  logic       day_tick;
  logic       load;
  logic [7:0] day_in;
  logic [7:0] month_in;
  logic [7:0] year_in;
  logic [7:0] day_out;
  logic [7:0] month_out;
  logic [7:0] year_out;
  logic       century_p;
  logic       load_err;

  modport master (
    output edit_en, btn_up, btn_dn, field_sel, day_tick, load, day_in, month_in, year_in,
    input  day_out, month_out, year_out, century_p, load_err
  );

  modport slave (
    input  edit_en, btn_up, btn_dn, field_sel, day_tick, load, day_in, month_in, year_in,
    output day_out, month_out, year_out, century_p, load_err
  );
endinterface

// File: rtl/fecha_bcd_editor_bcd_step.sv
// Two-digit BCD increment/decrement with wrap between lo and hi limits.
module bcd_step (
  input  logic [7:0] val,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic       up,
  output logic [7:0] nxt,
  output logic       wrap
);
  always_comb begin
    nxt  = val;
    wrap = 1'b0;
    if (up) begin
      if (val >= hi) begin
        nxt  = lo;
        wrap = 1'b1;
      end else if (val[3:0] == 4'd9) begin
        nxt = {val[7:4] + 4'd1, 4'd0};
      end else begin
        nxt = {val[7:4], val[3:0] + 4'd1};
      end
    end else begin
      if (val <= lo) begin
        nxt  = hi;
        wrap = 1'b1;
      end else if (val[3:0] == 4'd0) begin
        nxt = {val[7:4] - 4'd1, 4'd9};
      end else begin
        nxt = {val[7:4], val[3:0] - 4'd1};
      end
    end
  end
endmodule

// File: rtl/fecha_bcd_editor.sv
// BCD calendar date register: run-mode load/day advance, edit-mode button stepping with auto-repeat.
// Optional macro DATE_LEAP_EN (via fecha_pkg) enables 29-02 in years divisible by 4.
module fecha_bcd_editor
  import fecha_pkg::*;
#(
  parameter int         REPEAT_DLY = 50_000_000,
  parameter int         REPEAT_PER = 10_000_000,
  parameter logic [7:0] RST_DAY    = 8'h01,
  parameter logic [7:0] RST_MONTH  = 8'h01,
  parameter logic [7:0] RST_YEAR   = 8'h00
) (
  input logic               clk,
  input logic               reset,
  fecha_bcd_editor_if.slave bus
);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(REP_MAX) + 1;
  localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_M1 = CNT_W'(REPEAT_PER - 1);

  logic [7:0] day_reg, month_reg, year_reg, day_next, month_next, year_next;
  logic       cent_reg, err_reg, cent_next, err_next;
  logic       flag_up_reg, flag_dn_reg, rep_up_reg, rep_dn_reg, edit_d_reg;
  logic       flag_up_next, flag_dn_next, rep_up_next, rep_dn_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  field_e     fsel;
  logic       edit_active, any_hi, hold_fire, up_evt, dn_evt, clash, do_step, step_up, load_ok;
  logic [7:0] max_cur, max_m, max_y;
  logic [7:0] cur_v [3];
  logic [7:0] lo_v  [3];
  logic [7:0] hi_v  [3];
  logic [7:0] nxt_v [3];
  logic [2:0] wrap_v;

  assign fsel        = field_e'(bus.field_sel);
  assign edit_active = bus.edit_en & edit_d_reg;
  assign max_cur     = bcd_max_day(month_reg, year_reg);

  // Day, month and year steppers share one direction: up for ticks, button direction when editing.
  assign cur_v = '{day_reg, month_reg, year_reg};
  assign lo_v  = '{BCD_01, BCD_01, BCD_00};
  assign hi_v  = '{max_cur, BCD_12, BCD_99};
  for (genvar gi = 0; gi < 3; gi++) begin : g_step
    bcd_step u_step (
      .val  (cur_v[gi]),
      .lo   (lo_v[gi]),
      .hi   (hi_v[gi]),
      .up   (step_up),
      .nxt  (nxt_v[gi]),
      .wrap (wrap_v[gi])
    );
  end

  assign max_m = bcd_max_day(nxt_v[1], year_reg);
  assign max_y = bcd_max_day(month_reg, nxt_v[2]);

  assign load_ok = bcd_valid(bus.day_in) && bcd_valid(bus.month_in) && bcd_valid(bus.year_in)
                && (bus.month_in >= BCD_01) && (bus.month_in <= BCD_12)
                && (bus.day_in >= BCD_01) && (bus.day_in <= bcd_max_day(bus.month_in, bus.year_in));

  // Shared repeat timer: first limit is the initial delay, then the repeat period.
  assign any_hi    = bus.btn_up | bus.btn_dn;
  assign hold_fire = any_hi && (cnt_reg == ((rep_up_reg | rep_dn_reg) ? PER_M1 : DLY_M1));
  assign up_evt    = (flag_up_reg & ~bus.btn_up & ~rep_up_reg) | (bus.btn_up & hold_fire);
  assign dn_evt    = (flag_dn_reg & ~bus.btn_dn & ~rep_dn_reg) | (bus.btn_dn & hold_fire);
  assign clash     = (up_evt & dn_evt) | (flag_up_reg & ~bus.btn_up & flag_dn_reg & ~bus.btn_dn);
  assign do_step   = edit_active & (up_evt | dn_evt) & ~clash;
  assign step_up   = bus.edit_en ? up_evt : 1'b1;

  always_comb begin
    flag_up_next = 1'b0;
    flag_dn_next = 1'b0;
    rep_up_next  = 1'b0;
    rep_dn_next  = 1'b0;
    cnt_next     = '0;
    if (edit_active) begin
      flag_up_next = bus.btn_up & ~clash;
      flag_dn_next = bus.btn_dn & ~clash;
      rep_up_next  = bus.btn_up & (rep_up_reg | hold_fire);
      rep_dn_next  = bus.btn_dn & (rep_dn_reg | hold_fire);
      cnt_next     = (any_hi && !hold_fire) ? cnt_reg + 1'b1 : '0;
    end
  end

  always_comb begin
    day_next   = day_reg;
    month_next = month_reg;
    year_next  = year_reg;
    cent_next  = 1'b0;
    err_next   = 1'b0;
    if (!bus.edit_en) begin
      if (bus.load) begin
        if (load_ok) begin
          day_next   = bus.day_in;
          month_next = bus.month_in;
          year_next  = bus.year_in;
        end else begin
          err_next = 1'b1;
        end
      end else if (bus.day_tick) begin
        day_next = nxt_v[0];
        if (wrap_v[0]) begin
          month_next = nxt_v[1];
          if (wrap_v[1]) begin
            year_next = nxt_v[2];
            cent_next = wrap_v[2];
          end
        end
      end
    end else if (do_step) begin
      case (fsel)
        FIELD_DAY:   day_next = nxt_v[0];
        FIELD_MONTH: begin
          month_next = nxt_v[1];
          if (day_reg > max_m) day_next = max_m;
        end
        FIELD_YEAR:  begin
          year_next = nxt_v[2];
          if (day_reg > max_y) day_next = max_y;
        end
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      day_reg     <= RST_DAY;
      month_reg   <= RST_MONTH;
      year_reg    <= RST_YEAR;
      cent_reg    <= 1'b0;
      err_reg     <= 1'b0;
      flag_up_reg <= 1'b0;
      flag_dn_reg <= 1'b0;
      rep_up_reg  <= 1'b0;
      rep_dn_reg  <= 1'b0;
      edit_d_reg  <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      day_reg     <= day_next;
      month_reg   <= month_next;
      year_reg    <= year_next;
      cent_reg    <= cent_next;
      err_reg     <= err_next;
      flag_up_reg <= flag_up_next;
      flag_dn_reg <= flag_dn_next;
      rep_up_reg  <= rep_up_next;
      rep_dn_reg  <= rep_dn_next;
      edit_d_reg  <= bus.edit_en;
      cnt_reg     <= cnt_next;
    end
  end

  assign bus.day_out   = day_reg;
  assign bus.month_out = month_reg;
  assign bus.year_out  = year_reg;
  assign bus.century_p = cent_reg;
  assign bus.load_err  = err_reg;
endmodule

// File: tb/tb_fecha_bcd_editor.sv
// Directed bench for fecha_bcd_editor (REPEAT_DLY=8, REPEAT_PER=3); honours DATE_LEAP_EN if defined.
module tb_fecha_bcd_editor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  fecha_bcd_editor_if bus ();

  fecha_bcd_editor #(
    .REPEAT_DLY (8),
    .REPEAT_PER (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_date(input string tag, input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
    chk({tag, ".day"}, bus.day_out, d);
    chk({tag, ".month"}, bus.month_out, m);
    chk({tag, ".year"}, bus.year_out, y);
  endtask

  task automatic do_load(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
    bus.day_in = d; bus.month_in = m; bus.year_in = y; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    $display("[TB] load %h-%h-%h -> %h-%h-%h err=%0b", d, m, y,
             bus.day_out, bus.month_out, bus.year_out, bus.load_err);
  endtask

  task automatic tick();
    bus.day_tick = 1'b1;
    cyc();
    bus.day_tick = 1'b0;
    $display("[TB] tick -> %h-%h-%h cent=%0b", bus.day_out, bus.month_out, bus.year_out, bus.century_p);
  endtask

  task automatic press(input logic up, input logic dn);
    bus.btn_up = up; bus.btn_dn = dn;
    cyc();
    bus.btn_up = 1'b0; bus.btn_dn = 1'b0;
    cyc();
    $display("[TB] press up=%0b dn=%0b field=%0d -> %h-%h-%h", up, dn, bus.field_sel,
             bus.day_out, bus.month_out, bus.year_out);
  endtask

  task automatic set_edit(input logic en);
    bus.edit_en = en;
    cyc();
    $display("[TB] edit_en=%0b", en);
  endtask

  logic [7:0] bad_d [8] = '{8'h32, 8'h00, 8'h15, 8'h15, 8'h1A, 8'h31, 8'h30, 8'h29};
  logic [7:0] bad_m [8] = '{8'h01, 8'h01, 8'h00, 8'h13, 8'h01, 8'h04, 8'h02, 8'h02};
  logic [7:0] bad_y [8] = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h24, 8'h21};

  initial begin
    logic [7:0] exp_y;
    bus.edit_en = 1'b0; bus.btn_up = 1'b0; bus.btn_dn = 1'b0; bus.field_sel = 2'd0;
    bus.day_tick = 1'b0; bus.load = 1'b0;
    bus.day_in = 8'h00; bus.month_in = 8'h00; bus.year_in = 8'h00;

    // 1. reset values
    #2 reset = 1'b0;
    cyc();
    chk_date("rst_hold", 8'h01, 8'h01, 8'h00);
    reset = 1'b1;
    cyc();
    chk_date("rst_rel", 8'h01, 8'h01, 8'h00);
    chk("rst_cent", {7'd0, bus.century_p}, 8'd0);
    chk("rst_err", {7'd0, bus.load_err}, 8'd0);

    // 2. February end
    do_load(8'h28, 8'h02, 8'h24);
    chk_date("ld_2802", 8'h28, 8'h02, 8'h24);
    chk("ld_2802_err", {7'd0, bus.load_err}, 8'd0);
    tick();
`ifdef DATE_LEAP_EN
    chk_date("tick_2902", 8'h29, 8'h02, 8'h24);
    tick();
`endif
    chk_date("tick_0103", 8'h01, 8'h03, 8'h24);
    do_load(8'h29, 8'h02, 8'h24);
`ifdef DATE_LEAP_EN
    chk("ld_2902_err", {7'd0, bus.load_err}, 8'd0);
    chk_date("ld_2902", 8'h29, 8'h02, 8'h24);
`else
    chk("ld_2902_err", {7'd0, bus.load_err}, 8'd1);
    chk_date("ld_2902", 8'h01, 8'h03, 8'h24);
`endif

    // 3. century rollover and rejected loads
    do_load(8'h31, 8'h12, 8'h99);
    chk_date("ld_311299", 8'h31, 8'h12, 8'h99);
    tick();
    chk_date("century", 8'h01, 8'h01, 8'h00);
    chk("century_p_hi", {7'd0, bus.century_p}, 8'd1);
    cyc();
    chk("century_p_lo", {7'd0, bus.century_p}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      do_load(bad_d[i], bad_m[i], bad_y[i]);
      chk($sformatf("bad%0d_err", i), {7'd0, bus.load_err}, 8'd1);
      chk_date($sformatf("bad%0d", i), 8'h01, 8'h01, 8'h00);
    end
    cyc();
    chk("err_pulse_lo", {7'd0, bus.load_err}, 8'd0);

    // 4. day field edits
    do_load(8'h31, 8'h01, 8'h21);
    set_edit(1'b1);
    bus.field_sel = 2'd0;
    bus.btn_up = 1'b1;
    cyc();
    chk("held_no_step", bus.day_out, 8'h31);
    bus.btn_up = 1'b0;
    cyc();
    chk_date("day_up_wrap", 8'h01, 8'h01, 8'h21);
    cyc();
    chk("day_after_rel", bus.day_out, 8'h01);
    do_load(8'h15, 8'h06, 8'h22);
    chk_date("edit_load_ign", 8'h01, 8'h01, 8'h21);
    chk("edit_load_noerr", {7'd0, bus.load_err}, 8'd0);
    set_edit(1'b0);
    do_load(8'h01, 8'h04, 8'h21);
    set_edit(1'b1);
    press(1'b0, 1'b1);
    chk_date("day_dn_wrap", 8'h30, 8'h04, 8'h21);
    press(1'b1, 1'b1);
    chk_date("both_rel", 8'h30, 8'h04, 8'h21);
    press(1'b0, 1'b1);
    chk("day_dn", bus.day_out, 8'h29);

    // 5. month clamp and year wrap
    set_edit(1'b0);
    do_load(8'h31, 8'h01, 8'h21);
    set_edit(1'b1);
    bus.field_sel = 2'd1;
    press(1'b1, 1'b0);
    chk_date("month_clamp", 8'h28, 8'h02, 8'h21);
    bus.field_sel = 2'd3;
    press(1'b1, 1'b0);
    chk_date("field_none", 8'h28, 8'h02, 8'h21);
    set_edit(1'b0);
    do_load(8'h15, 8'h06, 8'h99);
    set_edit(1'b1);
    bus.field_sel = 2'd2;
    press(1'b1, 1'b0);
    chk_date("year_wrap", 8'h15, 8'h06, 8'h00);
    chk("year_wrap_cent", {7'd0, bus.century_p}, 8'd0);

    // 6. hold-to-repeat on year
    set_edit(1'b0);
    do_load(8'h10, 8'h06, 8'h05);
    set_edit(1'b1);
    bus.field_sel = 2'd2;
    bus.btn_up = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      exp_y = 8'h05 + ((k >= 8) ? 8'd1 : 8'd0) + ((k >= 11) ? 8'd1 : 8'd0) + ((k >= 14) ? 8'd1 : 8'd0);
      $display("[TB] hold cycle %0d -> year %h", k, bus.year_out);
      chk($sformatf("hold_k%0d", k), bus.year_out, exp_y);
    end
    bus.btn_up = 1'b0;
    cyc();
    chk_date("hold_rel", 8'h10, 8'h06, 8'h08);
    tick();
    chk_date("edit_tick_ign", 8'h10, 8'h06, 8'h08);

    // 1b. reset during a hold
    bus.btn_up = 1'b1;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    #1;
    chk_date("rst_mid_hold", 8'h01, 8'h01, 8'h00);
    chk("rst_mid_cent", {7'd0, bus.century_p}, 8'd0);
    bus.btn_up = 1'b0;
    @(negedge clk);
    cyc();
    reset = 1'b1;
    cyc(); cyc();
    chk_date("rst_after", 8'h01, 8'h01, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
